// File: rtl/issue_queue_free_list_pkg.sv
// Shared scheduler types and default widths for the issue-queue free list.
package issue_queue_free_list_pkg;

    localparam int unsigned ISSUE_QUEUE_ENTRY_NUM  = 16;
    localparam int unsigned DISPATCH_WIDTH         = 2;
    localparam int unsigned ISSUE_WIDTH            = 2;
    localparam int unsigned ISSUE_QUEUE_INDEX_BITS = $clog2(ISSUE_QUEUE_ENTRY_NUM);

    typedef logic [ISSUE_QUEUE_INDEX_BITS-1:0] IssueQueueIndexPath;
    typedef logic [ISSUE_QUEUE_INDEX_BITS:0]   IssueQueueCountPath;

endpackage

// File: rtl/issue_queue_free_list_compactor.sv
// Exclusive prefix popcount: per-port offset among asserted bits, plus total.
module issue_queue_free_list_compactor #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned CNT_BITS = 2
) (
    input  logic [WIDTH-1:0]          req_i,
    output logic [WIDTH*CNT_BITS-1:0] offset_o,
    output logic [CNT_BITS-1:0]       total_o
);

    logic [CNT_BITS-1:0] acc;

    always_comb begin
        offset_o = '0;
        acc      = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            offset_o[i*CNT_BITS +: CNT_BITS] = acc;
            acc = acc + CNT_BITS'(req_i[i]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/issue_queue_free_list.sv
// Circular free list of issue-queue entry indices feeding dispatch.
// Define ISSUE_QUEUE_FREE_LIST_CHECK_EN to add busy tracking and protocol checks.
module issue_queue_free_list
    import issue_queue_free_list_pkg::*;
#(
    parameter int unsigned ENTRY_NUM     = ISSUE_QUEUE_ENTRY_NUM,
    parameter int unsigned ALLOC_WIDTH   = DISPATCH_WIDTH,
    parameter int unsigned RELEASE_WIDTH = ISSUE_WIDTH,
    localparam int unsigned INDEX_BITS   = $clog2(ENTRY_NUM)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                stall,
    input  logic                                flush,
    input  logic [ALLOC_WIDTH-1:0]              allocReq,
    output logic [ALLOC_WIDTH*INDEX_BITS-1:0]   allocPtr,
    output logic                                canAllocate,
    input  logic [RELEASE_WIDTH-1:0]            releaseEntry,
    input  logic [RELEASE_WIDTH*INDEX_BITS-1:0] releasePtr,
    output logic [INDEX_BITS:0]                 freeCount,
    output logic                                error
);

    localparam int unsigned A_CB    = $clog2(ALLOC_WIDTH + 1);
    localparam int unsigned R_CB    = $clog2(RELEASE_WIDTH + 1);
    localparam int unsigned COUNT_W = INDEX_BITS + 1;
    localparam int unsigned SUM_W   = INDEX_BITS + 2;

    logic [INDEX_BITS-1:0] list_q [ENTRY_NUM];
    logic [INDEX_BITS-1:0] list_d [ENTRY_NUM];
    logic [INDEX_BITS-1:0] head_q, head_d, tail_q, tail_d, rd_idx;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic                  error_q, error_d;

    logic [ALLOC_WIDTH*A_CB-1:0]   alloc_off;
    logic [A_CB-1:0]               alloc_tot, alloc_n;
    logic [RELEASE_WIDTH*R_CB-1:0] rel_off;
    logic [R_CB-1:0]               rel_tot;
    logic [SUM_W-1:0]              sum;
    logic                          fire, overflow, chk_err;

    issue_queue_free_list_compactor #(.WIDTH(ALLOC_WIDTH), .CNT_BITS(A_CB)) u_alloc_cmp (
        .req_i    (allocReq),
        .offset_o (alloc_off),
        .total_o  (alloc_tot)
    );

    issue_queue_free_list_compactor #(.WIDTH(RELEASE_WIDTH), .CNT_BITS(R_CB)) u_rel_cmp (
        .req_i    (releaseEntry),
        .offset_o (rel_off),
        .total_o  (rel_tot)
    );

    assign canAllocate = (count_q >= COUNT_W'(ALLOC_WIDTH));
    assign fire        = ~stall & canAllocate;
    assign alloc_n     = fire ? alloc_tot : '0;
    assign freeCount   = count_q;
    assign error       = error_q;

    // Requested ports read compacted slots; idle ports read their own slot.
    always_comb begin
        allocPtr = '0;
        rd_idx   = '0;
        for (int unsigned i = 0; i < ALLOC_WIDTH; i++) begin
            if (allocReq[i]) rd_idx = head_q + INDEX_BITS'(alloc_off[i*A_CB +: A_CB]);
            else             rd_idx = head_q + INDEX_BITS'(i);
            allocPtr[i*INDEX_BITS +: INDEX_BITS] = list_q[rd_idx];
        end
    end

    always_comb begin
        list_d   = list_q;
        head_d   = head_q + INDEX_BITS'(alloc_n);
        tail_d   = tail_q + INDEX_BITS'(rel_tot);
        for (int unsigned j = 0; j < RELEASE_WIDTH; j++) begin
            if (releaseEntry[j])
                list_d[tail_q + INDEX_BITS'(rel_off[j*R_CB +: R_CB])] =
                    releasePtr[j*INDEX_BITS +: INDEX_BITS];
        end
        sum      = SUM_W'(count_q) + SUM_W'(rel_tot) - SUM_W'(alloc_n);
        overflow = (sum > SUM_W'(ENTRY_NUM));
        count_d  = overflow ? COUNT_W'(ENTRY_NUM) : sum[COUNT_W-1:0];
        error_d  = error_q | overflow | chk_err;
        if (flush) begin
            for (int unsigned i = 0; i < ENTRY_NUM; i++) list_d[i] = INDEX_BITS'(i);
            head_d  = '0;
            tail_d  = '0;
            count_d = COUNT_W'(ENTRY_NUM);
            error_d = error_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRY_NUM; i++) list_q[i] <= INDEX_BITS'(i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= COUNT_W'(ENTRY_NUM);
            error_q <= 1'b0;
        end else begin
            list_q  <= list_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

`ifdef ISSUE_QUEUE_FREE_LIST_CHECK_EN
    logic [ENTRY_NUM-1:0] busy_q, busy_d;

    always_comb begin
        busy_d  = busy_q;
        chk_err = ~canAllocate & (|allocReq);
        for (int unsigned j = 0; j < RELEASE_WIDTH; j++) begin
            if (releaseEntry[j]) begin
                if (!busy_q[releasePtr[j*INDEX_BITS +: INDEX_BITS]]) chk_err = 1'b1;
                busy_d[releasePtr[j*INDEX_BITS +: INDEX_BITS]] = 1'b0;
                for (int unsigned k = j + 1; k < RELEASE_WIDTH; k++) begin
                    if (releaseEntry[k] && (releasePtr[k*INDEX_BITS +: INDEX_BITS] ==
                                            releasePtr[j*INDEX_BITS +: INDEX_BITS]))
                        chk_err = 1'b1;
                end
            end
        end
        for (int unsigned i = 0; i < ALLOC_WIDTH; i++) begin
            if (fire && allocReq[i]) busy_d[allocPtr[i*INDEX_BITS +: INDEX_BITS]] = 1'b1;
        end
        if (flush) busy_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_issue_queue_free_list.sv
// Directed scoreboard bench for issue_queue_free_list (default 16/2/2 configuration).
module tb_issue_queue_free_list;

`ifdef ISSUE_QUEUE_FREE_LIST_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, stall, flush;
    logic [1:0] allocReq, releaseEntry;
    logic [7:0] allocPtr, releasePtr;
    logic       canAllocate, error;
    logic [4:0] freeCount;

    issue_queue_free_list #(.ENTRY_NUM(16), .ALLOC_WIDTH(2), .RELEASE_WIDTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .allocReq     (allocReq),
        .allocPtr     (allocPtr),
        .canAllocate  (canAllocate),
        .releaseEntry (releaseEntry),
        .releasePtr   (releasePtr),
        .freeCount    (freeCount),
        .error        (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] ptr;
        bit         chk_ptr;
        logic       can;
        logic [4:0] fc;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Expectations describe outputs seen during the cycle the vector is applied.
    task automatic step(input string nm, input logic st, input logic fl,
                        input logic [1:0] areq, input logic [1:0] rel,
                        input logic [3:0] rp1, input logic [3:0] rp0,
                        input logic [3:0] e1, input logic [3:0] e0, input bit cp,
                        input logic ecan, input logic [4:0] efc, input logic eerr);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = 1'b1;
        stall        = st;
        flush        = fl;
        allocReq     = areq;
        releaseEntry = rel;
        releasePtr   = {rp1, rp0};
        e.name    = nm;
        e.ptr     = {e1, e0};
        e.chk_ptr = cp;
        e.can     = ecan;
        e.fc      = efc;
        e.err     = eerr;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk_ptr) begin
                    total++;
                    if (allocPtr !== e.ptr) begin
                        bad++;
                        $display("FAIL %s allocPtr got=%h exp=%h", e.name, allocPtr, e.ptr);
                    end
                end
                total++;
                if (canAllocate !== e.can) begin
                    bad++;
                    $display("FAIL %s canAllocate got=%b exp=%b", e.name, canAllocate, e.can);
                end
                total++;
                if (freeCount !== e.fc) begin
                    bad++;
                    $display("FAIL %s freeCount got=%0d exp=%0d", e.name, freeCount, e.fc);
                end
                total++;
                if (error !== e.err) begin
                    bad++;
                    $display("FAIL %s error got=%b exp=%b", e.name, error, e.err);
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        allocReq = '0; releaseEntry = '0; releasePtr = '0;
        repeat (2) @(posedge clk);

        step("reset", 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 1, 1, 16, 0);
        for (int k = 1; k <= 8; k++)
            step("fill", 0, 0, 2'b11, 2'b00, 0, 0, 4'(2*k-1), 4'(2*k-2), 1, 1, 5'(18-2*k), 0);
        step("alloc_empty",    0, 0, 2'b11, 2'b00, 0, 0, 1, 0, 1, 0, 0, 0);
        step("rel_5_9",        0, 0, 2'b00, 2'b11, 9, 5, 1, 0, 1, 0, 0, CHK);
        step("after_rel",      0, 0, 2'b00, 2'b11, 3, 0, 9, 5, 1, 1, 2, CHK);
        step("alloc2_rel1",    0, 0, 2'b11, 2'b01, 0, 7, 9, 5, 1, 1, 4, CHK);
        step("alloc_p0",       0, 0, 2'b01, 2'b00, 0, 0, 3, 0, 1, 1, 3, CHK);
        step("alloc_p1_head3", 0, 0, 2'b10, 2'b00, 0, 0, 3, 3, 1, 1, 2, CHK);
        step("tail_visible",   0, 0, 2'b00, 2'b00, 0, 0, 5, 7, 1, 0, 1, CHK);
        step("rel_3",          0, 0, 2'b00, 2'b01, 0, 3, 5, 7, 1, 0, 1, CHK);
        step("stall",          1, 0, 2'b11, 2'b10, 0, 0, 3, 7, 1, 1, 2, CHK);
        step("flush",          0, 1, 2'b11, 2'b01, 0, 9, 3, 7, 1, 1, 3, CHK);
        step("post_flush",     0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 1, 1, 16, CHK);
        step("overflow",       0, 0, 2'b00, 2'b01, 0, 2, 1, 0, 1, 1, 16, CHK);
        step("flush2",         0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 16, 1);
        step("sticky",         0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 1, 1, 16, 1);

        for (int n = 0; n < 5 && q.size() > 0; n++) @(posedge clk);
        if (q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_queue_free_list.md
Name: issue_queue_free_list

Overview:
- Circular free list of issue-queue entry indices, sitting between the dispatch stage and the wakeup/select structures.
- Supplies up to ALLOC_WIDTH free entry pointers per cycle to dispatch; these become the write pointers into wakeup logic and destination RAM.
- Reclaims up to RELEASE_WIDTH entries per cycle from the wakeup pipeline register's release port.
- Owns the issue-queue capacity: dispatch stalls on its canAllocate output.

Parameters:
- ENTRY_NUM, 16, issue-queue entries; power of two, >= ALLOC_WIDTH.
- ALLOC_WIDTH, 2, allocation ports (dispatch width).
- RELEASE_WIDTH, 2, release ports (issue width).
- INDEX_BITS, $clog2(ENTRY_NUM), entry pointer width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- stall  in  1  dispatch stall; blocks allocation only.
- flush  in  1  all issue-queue entries invalidated; refill list.
- allocReq  in  ALLOC_WIDTH  per-port allocation request.
- allocPtr  out  ALLOC_WIDTH*INDEX_BITS  pointer for port i, slice i.
- canAllocate  out  1  freeCount >= ALLOC_WIDTH.
- releaseEntry  in  RELEASE_WIDTH  per-port release valid.
- releasePtr  in  RELEASE_WIDTH*INDEX_BITS  released entry index.
- freeCount  out  INDEX_BITS+1  free entries.
- error  out  1  sticky protocol-error flag.

Behaviour:
- State:
  - list[ENTRY_NUM] of INDEX_BITS.
  - head and tail, each INDEX_BITS, wrapping modulo ENTRY_NUM.
  - count, INDEX_BITS+1.
- Reset (rst=0 at a clk edge):
  - list[i]=i; head=0; tail=0; count=ENTRY_NUM; error=0.
  - Outputs after reset: allocPtr slice i = i, canAllocate=1, freeCount=ENTRY_NUM.
  - A reset mid-operation discards all in-flight allocations and releases.
- allocPtr (combinational from head, compacted):
  - The k-th asserted allocReq bit, counting from port 0, gets list[head+k].
  - Unrequested slices show list[head+their port index]. These slices are don't-care for dispatch but deterministic.
- Allocation fires when stall=0 and canAllocate=1.
  - head += popcount(allocReq); count -= popcount.
  - An allocation request while canAllocate=0 is ignored (no state change). Error is set only in the check build.
- Release is never stalled.
  - Valid release ports, in ascending port order, write list[tail+j]=releasePtr_j.
  - tail += popcount(releaseEntry); count += popcount.
- Simultaneous allocation and release:
  - Net count = count - allocN + relN.
  - Entries released in cycle t are allocatable no earlier than t+1; there is no bypass.
- Full/empty:
  - count never exceeds ENTRY_NUM by construction.
  - If count + relN - allocN > ENTRY_NUM, the update saturates at ENTRY_NUM and error is set.
  - count==0 forces canAllocate=0.
- flush=1 overrides the same-cycle alloc/release: next state equals the reset state, except error is retained.
- Latency:
  - Allocation pointers are valid in the same cycle as the request.
  - freeCount and canAllocate update one cycle after the fire.

Optional Feature:
- ISSUE_QUEUE_FREE_LIST_CHECK_EN enables the checks below.
  - A busy[ENTRY_NUM] vector is set on allocate and cleared on release; all bits clear on reset/flush.
  - error is set on any of:
    - release of a non-busy entry;
    - two ports releasing the same index in one cycle;
    - allocReq with canAllocate=0;
    - count overflow.
- Without the macro:
  - no busy vector;
  - error is set only on count overflow.
  - Behaviour is otherwise identical.

Decomposition:
- Shared package (SchedulerTypes):
  - IssueQueueIndexPath;
  - IssueQueueCountPath (INDEX_BITS+1);
  - ISSUE_QUEUE_ENTRY_NUM;
  - DISPATCH_WIDTH / ISSUE_WIDTH as the ALLOC/RELEASE defaults.
- Natural sub-module: issue_queue_free_list_compactor.
  - Combinational prefix-popcount over allocReq and releaseEntry.
  - Produces per-port offsets and totals; reused for both the head side and the tail side.

Test Plan:
- Reset, then allocReq=2'b11 for 8 cycles with no release:
  - pointers 0..15 issued in pairs;
  - freeCount reaches 0; canAllocate=0 after cycle 8;
  - a further request leaves head unchanged.
- From empty, release 5 then 9 in one cycle:
  - next cycle freeCount=2, canAllocate=1, allocPtr={9,5} (slice1=9, slice0=5).
- Same-cycle allocate 2 and release 1 at freeCount=4:
  - freeCount=3;
  - the released index appears at the tail and is not allocatable that cycle.
- allocReq=2'b10 with head=3:
  - port 1 receives list[3]; head becomes 4.
- stall=1 with allocReq=2'b11 and one release:
  - head unchanged; freeCount increments by 1.
- Mid-run flush=1 with simultaneous alloc/release:
  - next cycle head=0, tail=0, freeCount=16, allocPtr={1,0};
  - error unchanged.
  - Check build: releasing an entry not held asserts error, which stays asserted through the flush.
